// File: rtl/ss_pkg.sv
// ============================================================================
// Module   : ss_pkg
// Purpose  : shared FSM encoding and bit-order constants for the shift sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package ss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ss_bit_counter.sv
// ============================================================================
// Module   : ss_bit_counter
// Purpose  : clearable up-counter with a terminal-count flag at TERMINAL
// Revision : 1.0
// ============================================================================
`default_nettype none

module ss_bit_counter #(
  parameter int CW       = 5,
  parameter int TERMINAL = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] c_terminal = CW'(TERMINAL);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == c_terminal);

endmodule

`default_nettype wire

// File: rtl/ss_shift_sequencer.sv
// ============================================================================
// Module   : ss_shift_sequencer
// Purpose  : pushes a parallel word through an external serial shift chain and
//            reassembles the returning bit stream into a parallel word
// Revision : 1.0
// ============================================================================
`default_nettype none

module ss_shift_sequencer
  import ss_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_data_in,
  output logic             sr_leri,
  output logic             sr_shift_en,
  input  logic             sr_data_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int c_total = WIDTH + DEPTH;
  localparam int c_cnt_w = $clog2(c_total + 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   w_count;
  logic                 w_tc;
  logic [WIDTH-1:0]     r_word;
  logic [WIDTH-1:0]     r_out_data;
  logic                 r_dir;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_in_bit;

  assign w_accept = ena && in_valid && (r_state == ST_IDLE);
  assign w_step   = ena && (r_state == ST_SHIFT);

  ss_bit_counter #(
    .CW       (c_cnt_w),
    .TERMINAL (c_total - 1)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_accept),
    .enable (w_step),
    .count  (w_count),
    .tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)             w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_step && w_tc)       w_next_state = ST_DONE;
      ST_DONE:  if (ena && out_ready)     w_next_state = ST_IDLE;
      default:                            w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = ena && (r_state == ST_IDLE);
    sr_shift_en = w_step;
    sr_data_in  = (r_state == ST_SHIFT) && w_in_bit;
    out_valid   = (r_state == ST_DONE);
    busy        = (r_state != ST_IDLE);
  end

  // Bit i goes out at count i (LSB first) or WIDTH-1-i (MSB first); counts
  // beyond WIDTH match no bit and flush the chain with zeros.
  always_comb begin
    w_in_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_count == c_cnt_w'(r_dir ? (WIDTH - 1 - i) : i)) begin
        w_in_bit = r_word[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_dir      <= DIR_LSB;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_word <= in_data;
        r_dir  <= in_dir;
      end
      // The returning stream lags the outgoing one by exactly DEPTH shifts.
      for (int i = 0; i < WIDTH; i++) begin
        if (w_step && (w_count == c_cnt_w'(DEPTH + (r_dir ? (WIDTH - 1 - i) : i)))) begin
          r_out_data[i] <= sr_data_out;
        end
      end
    end
  end

  assign sr_leri  = r_dir;
  assign out_data = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_ss_shift_sequencer.sv
// ============================================================================
// Module   : tb_ss_shift_sequencer
// Purpose  : scoreboard bench for ss_shift_sequencer at chain depths 8, 1, 32
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ss_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_dir;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [2:0] in_ready, sdi, leri, sen, sdo, ov, busy;
  logic [7:0] od [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q [3][$];

  always #5 clk = ~clk;

  ss_shift_sequencer #(.WIDTH(8), .DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_dir(in_dir),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sr_data_in(sdi[0]),
    .sr_leri(leri[0]), .sr_shift_en(sen[0]), .sr_data_out(sdo[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready[0]), .busy(busy[0])
  );

  ss_shift_sequencer #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_dir(in_dir),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sr_data_in(sdi[1]),
    .sr_leri(leri[1]), .sr_shift_en(sen[1]), .sr_data_out(sdo[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready[1]), .busy(busy[1])
  );

  ss_shift_sequencer #(.WIDTH(8), .DEPTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_dir(in_dir),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .sr_data_in(sdi[2]),
    .sr_leri(leri[2]), .sr_shift_en(sen[2]), .sr_data_out(sdo[2]),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready[2]), .busy(busy[2])
  );

  // Ideal pure-delay chains
  logic [7:0]  ch0;
  logic        ch1;
  logic [31:0] ch2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch0 <= '0;
      ch1 <= 1'b0;
      ch2 <= '0;
    end else begin
      if (sen[0]) ch0 <= {ch0[6:0], sdi[0]};
      if (sen[1]) ch1 <= sdi[1];
      if (sen[2]) ch2 <= {ch2[30:0], sdi[2]};
    end
  end

  assign sdo = {ch2[31], ch1, ch0[7]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word on every output handshake
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && ov[i] && out_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_out_valid_%0d", i), 64'(ov[i]), 64'h0);
        end else begin
          check($sformatf("out_data_%0d", i), 64'(od[i]), 64'(exp_q[i].pop_front()));
        end
      end
    end
  end

  task automatic xfer(input int s, input logic [7:0] d, input logic dir,
                      input int ena_drop, input int rst_at,
                      output int lat, output int sh, output logic [63:0] seq,
                      output int leri_bad, output int frz_bad);
    int   hold;
    bit   dropped;
    logic fb;
    hold = 0; dropped = 0;
    lat = 0; sh = 0; seq = '0; leri_bad = 0; frz_bad = 0;
    fb = dir ? d[3'(7 - ena_drop)] : d[3'(ena_drop)];
    @(posedge clk); #2;
    in_data = d; in_dir = dir; in_valid[s] = 1'b1;
    if (rst_at < 0) exp_q[s].push_back(d);
    @(posedge clk); #2;
    in_valid[s] = 1'b0;
    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      lat++;
      if (leri[s] !== dir) leri_bad++;
      if (sen[s]) begin
        seq[6'(sh)] = sdi[s];
        sh++;
      end
      if (!ena && (sen[s] || in_ready[s] || (sdi[s] !== fb))) frz_bad++;
      if (ov[s]) break;
      @(posedge clk); #2;
      if (ena_drop >= 0 && !dropped && sh == ena_drop) begin
        ena = 1'b0; hold = 3; dropped = 1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) ena = 1'b1;
      end
      if (rst_at >= 0 && sh == rst_at) begin
        rst_n = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, sh, lb, fz;
    logic [63:0] seq;

    rst_n = 1'b0; ena = 1'b1; in_data = '0; in_dir = 1'b0;
    in_valid = '0; out_ready = 3'b111;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_out_valid", 64'(ov), 64'h0);
    check("rst_shift_en", 64'(sen), 64'h0);
    check("rst_sr_data_in", 64'(sdi), 64'h0);
    check("rst_sr_leri", 64'(leri), 64'h0);
    check("rst_out_data", 64'(od[0]), 64'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'h7);

    // 0xA5 LSB first
    xfer(0, 8'hA5, 1'b0, -1, -1, lat, sh, seq, lb, fz);
    check("a5_latency", 64'(lat), 64'd17);
    check("a5_shift_cycles", 64'(sh), 64'd16);
    check("a5_serial_seq", seq, 64'hA5);
    check("a5_leri", 64'(lb), 64'd0);

    // 0x81 MSB first
    xfer(0, 8'h81, 1'b1, -1, -1, lat, sh, seq, lb, fz);
    check("81_latency", 64'(lat), 64'd17);
    check("81_serial_seq", seq, 64'h81);
    check("81_leri_stable", 64'(lb), 64'd0);
    @(negedge clk);
    check("81_idle_leri_held", 64'(leri[0]), 64'h1);
    check("81_idle_busy", 64'(busy[0]), 64'h0);

    // 0x96 held in DONE with a second word pending
    out_ready[0] = 1'b0;
    xfer(0, 8'h96, 1'b0, -1, -1, lat, sh, seq, lb, fz);
    check("96_latency", 64'(lat), 64'd17);
    @(posedge clk); #2;
    in_data = 8'h42; in_dir = 1'b0; in_valid[0] = 1'b1;
    exp_q[0].push_back(8'h42);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_data", 64'(od[0]), 64'h96);
      check("hold_out_valid", 64'(ov[0]), 64'h1);
      check("hold_in_ready", 64'(in_ready[0]), 64'h0);
    end
    @(posedge clk); #2 out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("gap_busy", 64'(busy[0]), 64'h0);
    check("gap_in_ready", 64'(in_ready[0]), 64'h1);
    @(posedge clk); #2 in_valid[0] = 1'b0;
    @(negedge clk);
    check("second_busy", 64'(busy[0]), 64'h1);
    for (int i = 0; i < 40; i++) begin
      if (ov[0]) break;
      @(negedge clk);
    end
    check("second_done", 64'(ov[0]), 64'h1);

    // ena dropped for 3 cycles at count 5
    xfer(0, 8'hC3, 1'b0, 5, -1, lat, sh, seq, lb, fz);
    check("ena_latency", 64'(lat), 64'd20);
    check("ena_shift_cycles", 64'(sh), 64'd16);
    check("ena_frozen", 64'(fz), 64'd0);
    check("ena_serial_seq", seq, 64'hC3);

    // reset pulse at count 10 aborts the transfer
    xfer(0, 8'h5A, 1'b0, -1, 10, lat, sh, seq, lb, fz);
    @(negedge clk);
    check("abort_busy", 64'(busy[0]), 64'h0);
    check("abort_out_valid", 64'(ov[0]), 64'h0);
    check("abort_shift_en", 64'(sen[0]), 64'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready[0]), 64'h1);
    xfer(0, 8'h3C, 1'b0, -1, -1, lat, sh, seq, lb, fz);
    check("3c_latency", 64'(lat), 64'd17);
    check("3c_serial_seq", seq, 64'h3C);

    // chain-depth extremes
    xfer(1, 8'hFF, 1'b0, -1, -1, lat, sh, seq, lb, fz);
    check("d1_latency", 64'(lat), 64'd10);
    check("d1_shift_cycles", 64'(sh), 64'd9);
    xfer(2, 8'h00, 1'b0, -1, -1, lat, sh, seq, lb, fz);
    check("d32_latency", 64'(lat), 64'd41);
    check("d32_shift_cycles", 64'(sh), 64'd40);
    xfer(2, 8'h6D, 1'b1, -1, -1, lat, sh, seq, lb, fz);
    check("d32_msb_latency", 64'(lat), 64'd41);
    check("d32_msb_serial_seq", seq, 64'hB6);

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ss_shift_sequencer.md
SS_SHIFT_SEQUENCER -- requirements
Module: ss_shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bits per transfer word.
REQ-002 Parameter DEPTH, default 8: stage count of the attached serial-in serial-out shift chain; legal range 1..32.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  design enable; low freezes all state.
REQ-006 in_data  input  WIDTH  parallel word to be sent through the chain.
REQ-007 in_dir  input  1  bit order: 0 = LSB first, 1 = MSB first.
REQ-008 in_valid  input  1  in_data and in_dir are valid.
REQ-009 in_ready  output  1  sequencer accepts a word this cycle.
REQ-010 sr_data_in  output  1  serial bit driven into the chain.
REQ-011 sr_leri  output  1  direction select to the chain; equals the latched in_dir.
REQ-012 sr_shift_en  output  1  chain advances one stage on this clock edge.
REQ-013 sr_data_out  input  1  serial bit returned from the chain's last stage.
REQ-014 out_data  output  WIDTH  reassembled word.
REQ-015 out_valid  output  1  out_data is valid.
REQ-016 out_ready  input  1  consumer takes out_data.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-019 IDLE: in_ready=1; when in_valid=1 and ena=1, the sequencer SHALL latch in_data and in_dir, clear the bit counter and enter SHIFT.
REQ-020 SHIFT: sr_shift_en=1 on each of exactly WIDTH+DEPTH consecutive ena-high cycles, counted 0..WIDTH+DEPTH-1.
REQ-021 At count k<WIDTH, sr_data_in SHALL be latched bit k (dir=0) or bit WIDTH-1-k (dir=1); at k>=WIDTH it SHALL be 0.
REQ-022 At count k with DEPTH<=k<DEPTH+WIDTH, sr_data_out SHALL be sampled into out_data bit k-DEPTH (dir=0) or WIDTH-1-(k-DEPTH) (dir=1), so a pure-delay chain yields out_data == in_data.
REQ-023 After count WIDTH+DEPTH-1, the FSM SHALL enter DONE with out_valid=1 on the next cycle.
REQ-024 DONE: out_valid and out_data SHALL be held stable until out_ready=1 is sampled; the FSM then SHALL return to IDLE.
REQ-025 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states SHALL be ignored, with no latching.
REQ-026 There SHALL be no IDLE bypass: back-to-back words incur one IDLE cycle, giving a minimum period of WIDTH+DEPTH+2 cycles.
REQ-027 ena=0 SHALL hold state, counter and outputs, and force sr_shift_en=0 and in_ready=0.
REQ-028 sr_leri SHALL be stable for the whole transfer; in IDLE it SHALL hold the last latched value.
REQ-029 The counter SHALL be $clog2(WIDTH+DEPTH+1) bits wide and SHALL never wrap within a transfer.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE, the counter 0, out_data 0, the latched word and direction 0, out_valid 0, sr_shift_en 0, sr_data_in 0, sr_leri 0 and busy 0.
REQ-031 Reset mid-SHIFT or mid-DONE SHALL abort the transfer without emitting out_valid; in_ready SHALL be 1 on the first ena-high cycle after release.

Structure
REQ-032 The state encoding and the direction constants (DIR_LSB=0, DIR_MSB=1) SHALL reside in the shared package ss_pkg.
REQ-033 The bit counter SHALL be the sub-module ss_bit_counter, with clear, enable and terminal-count outputs.
REQ-034 The shift chain itself SHALL be external to this block and connected at the top level.

Verification
REQ-035 WIDTH=8, DEPTH=8, ideal 8-stage delay model, in_data=0xA5, dir=0 -> out_valid after 17 cycles, out_data=0xA5, sr_shift_en high for exactly 16 cycles.
REQ-036 in_data=0x81, dir=1 -> sr_data_in sequence 1,0,0,0,0,0,0,1 then 8 zeros, sr_leri=1 throughout, out_data=0x81.
REQ-037 out_ready held 0 for 5 cycles in DONE, with a second in_valid pending -> out_data held, in_ready=0; the second word is accepted only after out_ready=1 and one IDLE cycle.
REQ-038 ena dropped for 3 cycles at count 5 -> counter and sr_data_in frozen, sr_shift_en=0; the transfer completes 3 cycles late with correct data.
REQ-039 rst_n pulsed low at count 10 -> busy=0 immediately, no out_valid, a new word 0x3C completes correctly.
REQ-040 DEPTH=1 with 0xFF and DEPTH=32 with 0x00 -> out_data matches in_data; latency is WIDTH+DEPTH+1.
